alu_muldiv_seq: RTL and testbench

Multi-cycle sequencer that performs 32-bit unsigned multiply and divide by iterating the shared 32-bit ALU (SUB encoding: 000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 slt, 111 eq). It sits beside the EXU. It accepts one M-type request at a time over a valid/ready handshake, drives the ALU operand and op inputs for 32 iterations, and returns the result over a second valid/ready handshake. An external mux in the EXU grants it the ALU while alu_busy is high.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_muldiv_seq_if.sv | 30 +++
 rtl/alu_muldiv_seq.sv | 131 +++++++++++++
 tb/tb_alu_muldiv_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, M-type op encodings and sequencer states
package alu_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_EQ  = 3'b111;

    typedef enum logic [1:0] {
        MD_MUL   = 2'b00,
        MD_MULHU = 2'b01,
        MD_DIVU  = 2'b10,
        MD_REMU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// rtl/alu_muldiv_seq_if.sv - request/response handshakes and shared-ALU port bundle
interface alu_muldiv_seq_if;
    import alu_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_src1;
    logic [XLEN-1:0] req_src2;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            alu_busy;
    logic [XLEN-1:0] alu_r1;
    logic [XLEN-1:0] alu_r2;
    logic [2:0]      alu_sub;
    logic [XLEN-1:0] alu_sum;
    logic            alu_overflow;

    modport master (
        output req_valid, req_op, req_src1, req_src2, resp_ready, alu_sum, alu_overflow,
        input  req_ready, resp_valid, resp_data, alu_busy, alu_r1, alu_r2, alu_sub
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, resp_ready, alu_sum, alu_overflow,
        output req_ready, resp_valid, resp_data, alu_busy, alu_r1, alu_r2, alu_sub
    );

endinterface

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - 32-iteration unsigned mul/div sequencer driving the shared ALU
module alu_muldiv_seq
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    alu_muldiv_seq_if.slave   bus
);

    // a holds acc/rem, b holds lo/q, c holds mcand/dvsr
    state_e            state_q, state_d;
    md_op_e            op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   c_q, c_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              run;
    logic              is_div;
    logic [XLEN-1:0]   sh;
    logic              top;
    logic              carry;
    logic              borrow;
    logic [XLEN-1:0]   sum;
    logic              unused_overflow;

    assign run             = (state_q == RUN);
    assign is_div          = (op_q == MD_DIVU) || (op_q == MD_REMU);
    assign sh              = {a_q[XLEN-2:0], b_q[XLEN-1]};
    assign top             = a_q[XLEN-1];
    assign sum             = bus.alu_sum;
    assign unused_overflow = bus.alu_overflow;

    // The ALU exposes no carry-out, so it is recovered from operand and sum MSBs
    assign carry  = (a_q[XLEN-1] & c_q[XLEN-1]) | ((a_q[XLEN-1] | c_q[XLEN-1]) & ~sum[XLEN-1]);
    assign borrow = (~sh[XLEN-1] & c_q[XLEN-1]) | (~(sh[XLEN-1] ^ c_q[XLEN-1]) & sum[XLEN-1]);

    always_comb begin
        bus.alu_r1  = '0;
        bus.alu_r2  = '0;
        bus.alu_sub = ALU_ADD;
        if (run) begin
            bus.alu_r1  = is_div ? sh : a_q;
            bus.alu_r2  = c_q;
            bus.alu_sub = is_div ? ALU_SUB : ALU_ADD;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == DONE);
    assign bus.resp_data  = res_q;
    assign bus.alu_busy   = run;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d  = md_op_e'(bus.req_op);
                    a_d   = '0;
                    b_d   = bus.req_src1;
                    c_d   = bus.req_src2;
                    cnt_d = '0;
                    if (bus.req_op[1] && (bus.req_src2 == '0)) begin
                        state_d = DONE;
                        res_d   = (bus.req_op == MD_DIVU) ? '1 : bus.req_src1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div) begin
                    if (top | ~borrow) begin
                        a_d = sum;
                        b_d = {b_q[XLEN-2:0], 1'b1};
                    end else begin
                        a_d = sh;
                        b_d = {b_q[XLEN-2:0], 1'b0};
                    end
                end else if (b_q[0]) begin
                    a_d = {carry, sum[XLEN-1:1]};
                    b_d = {sum[0], b_q[XLEN-1:1]};
                end else begin
                    a_d = {1'b0, a_q[XLEN-1:1]};
                    b_d = {a_q[0], b_q[XLEN-1:1]};
                end
                // MULHU and REMU take the upper register, MUL and DIVU the lower one
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = DONE;
                    res_d   = op_q[0] ? a_d : b_d;
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= MD_MUL;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - checks the mul/div sequencer against an arithmetic reference
module tb_alu_muldiv_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq_if bus();

    alu_muldiv_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared ALU as the EXU would provide it
    always_comb begin
        bus.alu_overflow = 1'b0;
        case (bus.alu_sub)
            3'b000: begin
                bus.alu_sum = bus.alu_r1 + bus.alu_r2;
                bus.alu_overflow = (bus.alu_r1[31] == bus.alu_r2[31]) && (bus.alu_sum[31] != bus.alu_r1[31]);
            end
            3'b001: begin
                bus.alu_sum = bus.alu_r1 - bus.alu_r2;
                bus.alu_overflow = (bus.alu_r1[31] != bus.alu_r2[31]) && (bus.alu_sum[31] != bus.alu_r1[31]);
            end
            3'b010: bus.alu_sum = ~bus.alu_r1;
            3'b011: bus.alu_sum = bus.alu_r1 & bus.alu_r2;
            3'b100: bus.alu_sum = bus.alu_r1 | bus.alu_r2;
            3'b101: bus.alu_sum = bus.alu_r1 ^ bus.alu_r2;
            3'b110: bus.alu_sum = {31'd0, $signed(bus.alu_r1) < $signed(bus.alu_r2)};
            default: bus.alu_sum = {31'd0, bus.alu_r1 == bus.alu_r2};
        endcase
    end

    function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Runs one request; lat counts rising edges after the accepting edge until resp_valid (-1 on timeout)
    task automatic transact(input logic [1:0] op, input logic [31:0] s1, input logic [31:0] s2,
                            input int stall, output logic [31:0] data, output int lat,
                            output int busy, output bit ready_ok, output bit hold_ok, output bit idle_ok);
        int n;
        data = '0; lat = -1; busy = 0; hold_ok = 1'b1; idle_ok = 1'b0;
        @(negedge clk);
        ready_ok       = (bus.req_ready === 1'b1);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_src1   = s1;
        bus.req_src2   = s2;
        bus.resp_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op    = 2'($urandom);
        bus.req_src1  = $urandom;
        bus.req_src2  = $urandom;
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < 200) begin
            busy += int'(bus.alu_busy === 1'b1);
            @(negedge clk);
            n++;
        end
        if (bus.resp_valid !== 1'b1) begin
            bus.resp_ready = 1'b0;
            return;
        end
        lat  = n;
        data = bus.resp_data;
        for (int i = 0; i < stall; i++) begin
            if (bus.resp_data !== data || bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1)
                hold_ok = 1'b0;
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_ok        = (bus.req_ready === 1'b1) && (bus.resp_valid === 1'b0);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 7;
        if (bus.req_ready !== 1'b1)  begin bad++; $display("FAIL reset req_ready: got %b want 1", bus.req_ready); end
        if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset resp_valid: got %b want 0", bus.resp_valid); end
        if (bus.resp_data !== 32'd0) begin bad++; $display("FAIL reset resp_data: got %h want 0", bus.resp_data); end
        if (bus.alu_busy !== 1'b0)   begin bad++; $display("FAIL reset alu_busy: got %b want 0", bus.alu_busy); end
        if (bus.alu_r1 !== 32'd0)    begin bad++; $display("FAIL reset alu_r1: got %h want 0", bus.alu_r1); end
        if (bus.alu_r2 !== 32'd0)    begin bad++; $display("FAIL reset alu_r2: got %h want 0", bus.alu_r2); end
        if (bus.alu_sub !== 3'b000)  begin bad++; $display("FAIL reset alu_sub: got %b want 000", bus.alu_sub); end
        rst = 1'b0;
    endtask

    task automatic test_mul_basic();
        logic [31:0] d; int lat, busy; bit rdy, hold, idle;
        transact(MD_MUL, 32'd3, 32'd5, 0, d, lat, busy, rdy, hold, idle);
        total += 4;
        if (!rdy)              begin bad++; $display("FAIL mul3x5 req_ready: got 0 want 1"); end
        if (d !== 32'h0000000F) begin bad++; $display("FAIL mul3x5 data: got %h want 0000000f", d); end
        if (lat != 32)          begin bad++; $display("FAIL mul3x5 latency: got %0d want 32", lat); end
        if (busy != 32)         begin bad++; $display("FAIL mul3x5 busy cycles: got %0d want 32", busy); end
    endtask

    task automatic test_mul_edges();
        logic [31:0] d; int lat, busy; bit rdy, hold, idle;
        transact(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, d, lat, busy, rdy, hold, idle);
        total++;
        if (d !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mulhu max data: got %h want fffffffe", d); end
        transact(MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, d, lat, busy, rdy, hold, idle);
        total++;
        if (d !== 32'h0000_0001) begin bad++; $display("FAIL mul max data: got %h want 00000001", d); end
    endtask

    task automatic test_div();
        logic [31:0] d; int lat, busy; bit rdy, hold, idle;
        logic [31:0] exp_tab [4] = '{32'd14, 32'd2, 32'h2AAA_AAAA, 32'd2};
        logic [31:0] a_tab   [4] = '{32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b_tab   [4] = '{32'd7, 32'd7, 32'd3, 32'd3};
        for (int i = 0; i < 4; i++) begin
            transact((i % 2 == 0) ? MD_DIVU : MD_REMU, a_tab[i], b_tab[i], 0, d, lat, busy, rdy, hold, idle);
            total += 2;
            if (d !== exp_tab[i]) begin bad++; $display("FAIL div case %0d data: got %h want %h", i, d, exp_tab[i]); end
            if (lat != 32)        begin bad++; $display("FAIL div case %0d latency: got %0d want 32", i, lat); end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] d; int lat, busy; bit rdy, hold, idle;
        transact(MD_DIVU, 32'h1234, 32'd0, 0, d, lat, busy, rdy, hold, idle);
        total += 3;
        if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu by zero data: got %h want ffffffff", d); end
        if (lat != 0)            begin bad++; $display("FAIL divu by zero latency: got %0d want 0", lat); end
        if (busy != 0)           begin bad++; $display("FAIL divu by zero busy: got %0d want 0", busy); end
        transact(MD_REMU, 32'h1234, 32'd0, 0, d, lat, busy, rdy, hold, idle);
        total += 3;
        if (d !== 32'h1234) begin bad++; $display("FAIL remu by zero data: got %h want 00001234", d); end
        if (lat != 0)       begin bad++; $display("FAIL remu by zero latency: got %0d want 0", lat); end
        if (busy != 0)      begin bad++; $display("FAIL remu by zero busy: got %0d want 0", busy); end
    endtask

    task automatic test_stall();
        logic [31:0] d; int lat, busy; bit rdy, hold, idle;
        transact(MD_MUL, 32'd7, 32'd6, 5, d, lat, busy, rdy, hold, idle);
        total += 3;
        if (d !== 32'd42) begin bad++; $display("FAIL stall data: got %h want 0000002a", d); end
        if (!hold)        begin bad++; $display("FAIL stall hold: got changed want held with req_ready low"); end
        if (!idle)        begin bad++; $display("FAIL stall idle cycle: got busy want req_ready=1 resp_valid=0"); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d; int lat, busy; bit rdy, hold, idle; int seen;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = MD_DIVU;
        bus.req_src1 = 32'd1000; bus.req_src2 = 32'd9;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total += 3;
        if (bus.alu_busy !== 1'b0 || bus.alu_r1 !== 32'd0 || bus.alu_r2 !== 32'd0 || bus.alu_sub !== 3'b000) begin
            bad++; $display("FAIL abort alu outputs: got busy=%b r1=%h r2=%h sub=%b want all zero",
                            bus.alu_busy, bus.alu_r1, bus.alu_r2, bus.alu_sub);
        end
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            bad++; $display("FAIL abort handshake: got req_ready=%b resp_valid=%b want 1/0", bus.req_ready, bus.resp_valid);
        end
        if (bus.resp_data !== 32'd0) begin bad++; $display("FAIL abort resp_data: got %h want 0", bus.resp_data); end
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            seen += int'(bus.resp_valid === 1'b1);
        end
        bus.resp_ready = 1'b0;
        total++;
        if (seen != 0) begin bad++; $display("FAIL abort no response: got %0d valid cycles want 0", seen); end
        transact(MD_MUL, 32'd2, 32'd2, 0, d, lat, busy, rdy, hold, idle);
        total++;
        if (d !== 32'd4) begin bad++; $display("FAIL post-abort mul data: got %h want 00000004", d); end
    endtask

    task automatic test_random();
        logic [31:0] d, a, b, e; logic [1:0] op; int lat, busy; bit rdy, hold, idle; int st;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 255);
                default: b = $urandom;
            endcase
            st = $urandom_range(0, 3);
            e  = ref_md(op, a, b);
            transact(op, a, b, st, d, lat, busy, rdy, hold, idle);
            total += 3;
            if (d !== e) begin bad++; $display("FAIL random %0d op=%0d a=%h b=%h: got %h want %h", i, op, a, b, d, e); end
            if (lat != ((op[1] && b == 0) ? 0 : 32)) begin
                bad++; $display("FAIL random %0d latency: got %0d want %0d", i, lat, (op[1] && b == 0) ? 0 : 32);
            end
            if (!hold || !idle) begin bad++; $display("FAIL random %0d handshake: got hold=%b idle=%b want 1/1", i, hold, idle); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_src1 = '0; bus.req_src2 = '0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_mul_basic();
        test_mul_edges();
        test_div();
        test_div_zero();
        test_stall();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
